// File: rtl/mem_init_loader_if.sv
// Valid/ready byte stream feeding the boot loader.
// The source drives data/valid and the loader drives ready.
interface mem_init_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/mem_init_loader.sv
// Byte-stream boot loader: framed commands -> BRAM port-B word writes, CPU held in reset until RUN.
// Optional trailing XOR checksum byte per frame when LOADER_CHECKSUM_EN is defined.
module mem_init_loader #(
    parameter int unsigned ADDR_W    = 15,
    parameter logic [7:0]  CMD_INSTR = 8'hA5,
    parameter logic [7:0]  CMD_DATA  = 8'h5A,
    parameter logic [7:0]  CMD_RUN   = 8'hC3
) (
    input  logic              clk,
    input  logic              reset,
    mem_init_loader_if.slave  s_if,
    output logic [ADDR_W-1:0] instr_init_addr,
    output logic [ADDR_W-1:0] data_init_addr,
    output logic [31:0]       init_data,
    output logic              instr_init_enable,
    output logic              data_init_enable,
    output logic [3:0]        instr_init_we,
    output logic [3:0]        data_init_we,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [15:0]       words_written_o
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_WRITE, ST_CHK} state_t;
    localparam state_t ST_END = ST_CHK;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_WRITE} state_t;
    localparam state_t ST_END = ST_IDLE;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic               w_fire;
    logic               w_wr;
    logic [7:0]         w_byte;
    logic [1:0]         r_hdr_cnt;
    logic [1:0]         r_byte_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_remain;
    logic [31:0]        r_word;
    logic               r_is_data;
    logic               r_busy;
    logic               r_err;
    logic               r_cpu_reset;
    logic [15:0]        r_words;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    assign w_byte = s_if.s_data;
    assign w_fire = s_if.s_valid && s_if.s_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fire && (w_byte == CMD_INSTR || w_byte == CMD_DATA))
                    w_state_next = ST_HDR;
            end
            ST_HDR: begin
                // Last header byte is CNT_HI; a zero count skips the payload entirely
                if (w_fire && r_hdr_cnt == 2'd3)
                    w_state_next = ({w_byte, r_remain[7:0]} == 16'd0) ? ST_END : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (w_fire && r_byte_cnt == 2'd3)
                    w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_wr         = 1'b1;
                w_state_next = (r_remain == 16'd1) ? ST_END : ST_PAYLOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_fire)
                    w_state_next = ST_IDLE;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_if.s_ready      = (r_state != ST_WRITE);
        instr_init_enable = w_wr && !r_is_data;
        data_init_enable  = w_wr && r_is_data;
        instr_init_we     = {4{w_wr && !r_is_data}};
        data_init_we      = {4{w_wr && r_is_data}};
        instr_init_addr   = r_is_data ? '0 : r_addr;
        data_init_addr    = r_is_data ? r_addr : '0;
        init_data         = r_word;
        cpu_reset_o       = r_cpu_reset;
        busy_o            = r_busy;
        err_o             = r_err;
        words_written_o   = r_words;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdr_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_addr      <= '0;
            r_remain    <= '0;
            r_word      <= '0;
            r_is_data   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_words     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            if (r_state != ST_IDLE && w_state_next == ST_IDLE)
                r_busy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        if (w_byte == CMD_INSTR || w_byte == CMD_DATA) begin
                            r_is_data   <= (w_byte == CMD_DATA);
                            r_err       <= 1'b0;
                            r_words     <= '0;
                            r_busy      <= 1'b1;
                            r_cpu_reset <= 1'b1;
                            r_hdr_cnt   <= '0;
                            r_byte_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_csum      <= '0;
`endif
                        end else if (w_byte == CMD_RUN) begin
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (w_fire) begin
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        case (r_hdr_cnt)
                            2'd0:    r_addr   <= ADDR_W'(w_byte);
                            2'd1:    r_addr   <= ADDR_W'({w_byte, r_addr[7:0]});
                            2'd2:    r_remain <= {8'h00, w_byte};
                            default: r_remain <= {w_byte, r_remain[7:0]};
                        endcase
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ w_byte;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (w_fire) begin
                        r_word     <= {w_byte, r_word[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ w_byte;
`endif
                    end
                end
                ST_WRITE: begin
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_words  <= r_words + 16'd1;
                    r_remain <= r_remain - 16'd1;
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_fire && w_byte != r_csum)
                        r_err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_init_loader.sv
// Directed bench for mem_init_loader: frames, address wrap, RUN, errors, mid-frame reset, optional checksum.
module tb_mem_init_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] instr_init_addr, data_init_addr;
    logic [31:0] init_data;
    logic        instr_init_enable, data_init_enable;
    logic [3:0]  instr_init_we, data_init_we;
    logic        cpu_reset_o, busy_o, err_o;
    logic [15:0] words_written_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic        q_mem[$];
    logic [14:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [7:0]  fq[$];

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    mem_init_loader_if bus();

    mem_init_loader #(
        .ADDR_W(15), .CMD_INSTR(8'hA5), .CMD_DATA(8'h5A), .CMD_RUN(8'hC3)
    ) dut (
        .clk(clk), .reset(reset), .s_if(bus),
        .instr_init_addr(instr_init_addr), .data_init_addr(data_init_addr),
        .init_data(init_data),
        .instr_init_enable(instr_init_enable), .data_init_enable(data_init_enable),
        .instr_init_we(instr_init_we), .data_init_we(data_init_we),
        .cpu_reset_o(cpu_reset_o), .busy_o(busy_o), .err_o(err_o),
        .words_written_o(words_written_o)
    );

    always #5 clk = ~clk;

    // Write log: every enable pulse seen, tagged with the memory it hit
    always @(negedge clk) begin
        if (instr_init_enable) begin
            q_mem.push_back(1'b0); q_addr.push_back(instr_init_addr); q_data.push_back(init_data);
        end
        if (data_init_enable) begin
            q_mem.push_back(1'b1); q_addr.push_back(data_init_addr); q_data.push_back(init_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_mem.delete(); q_addr.delete(); q_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) check("ready_timeout", {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_fq(input bit with_csum);
        logic [7:0] x = '0;
        foreach (fq[i]) begin
            send_byte(fq[i]);
            if (i > 0) x ^= fq[i];
        end
        if (with_csum && CSUM) send_byte(x);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(5);
        check("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("rst_s_ready",   {31'd0, bus.s_ready}, 32'd1);
        check("rst_enables",   {30'd0, instr_init_enable, data_init_enable}, 32'd0);
        check("rst_we",        {24'd0, instr_init_we, data_init_we}, 32'd0);
        check("rst_err",       {31'd0, err_o}, 32'd0);
        check("rst_busy",      {31'd0, busy_o}, 32'd0);
        check("rst_words",     {16'd0, words_written_o}, 32'd0);
        check("rst_init_data", init_data, 32'd0);

        // Instruction frame, two words at 0x0010
        clear_log();
        fq = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
        send_fq(1'b0);
        check("f1_busy_mid", {31'd0, busy_o}, 32'd1);
        send_byte(8'h12);
        check("f1_lat_en",   {31'd0, instr_init_enable}, 32'd1);
        check("f1_lat_we",   {28'd0, instr_init_we}, 32'hF);
        check("f1_lat_addr", {17'd0, instr_init_addr}, 32'h10);
        check("f1_lat_data", init_data, 32'h12345678);
        check("f1_lat_rdy",  {31'd0, bus.s_ready}, 32'd0);
        check("f1_lat_den",  {31'd0, data_init_enable}, 32'd0);
        fq = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fq.delete(0);
        foreach (fq[i]) send_byte(fq[i]);
        if (CSUM) send_byte(8'h10 ^ 8'h02 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
        idle(3);
        check("f1_nwr",   q_mem.size(), 32'd2);
        check("f1_mem0",  {31'd0, q_mem[0]}, 32'd0);
        check("f1_addr0", {17'd0, q_addr[0]}, 32'h10);
        check("f1_data0", q_data[0], 32'h12345678);
        check("f1_mem1",  {31'd0, q_mem[1]}, 32'd0);
        check("f1_addr1", {17'd0, q_addr[1]}, 32'h11);
        check("f1_data1", q_data[1], 32'hDEADBEEF);
        check("f1_words", {16'd0, words_written_o}, 32'd2);
        check("f1_busy",  {31'd0, busy_o}, 32'd0);
        check("f1_err",   {31'd0, err_o}, 32'd0);

        // Data frame wrapping at the top of the address space, then RUN
        clear_log();
        fq = '{8'h5A, 8'hFF, 8'h7F, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_fq(1'b1);
        idle(3);
        check("f2_nwr",   q_mem.size(), 32'd2);
        check("f2_mem0",  {31'd0, q_mem[0]}, 32'd1);
        check("f2_addr0", {17'd0, q_addr[0]}, 32'h7FFF);
        check("f2_data0", q_data[0], 32'h44332211);
        check("f2_mem1",  {31'd0, q_mem[1]}, 32'd1);
        check("f2_addr1", {17'd0, q_addr[1]}, 32'h0000);
        check("f2_data1", q_data[1], 32'h88776655);
        check("f2_cpu_held", {31'd0, cpu_reset_o}, 32'd1);
        send_byte(8'hC3);
        check("run_cpu", {31'd0, cpu_reset_o}, 32'd0);
        send_byte(8'hC3);
        check("run_again", {31'd0, cpu_reset_o}, 32'd0);

        // Bad command, then a zero-count frame clears the error
        clear_log();
        send_byte(8'h42);
        check("bad_err",  {31'd0, err_o}, 32'd1);
        check("bad_cpu",  {31'd0, cpu_reset_o}, 32'd0);
        check("bad_busy", {31'd0, busy_o}, 32'd0);
        send_byte(8'hA5);
        check("z_err_clr", {31'd0, err_o}, 32'd0);
        check("z_busy",    {31'd0, busy_o}, 32'd1);
        check("z_cpu",     {31'd0, cpu_reset_o}, 32'd1);
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        fq.delete(0);
        foreach (fq[i]) send_byte(fq[i]);
        if (CSUM) send_byte(8'h00);
        check("z_busy_end", {31'd0, busy_o}, 32'd0);
        idle(2);
        check("z_nwr",   q_mem.size(), 32'd0);
        check("z_words", {16'd0, words_written_o}, 32'd0);

        // Reset in the middle of a payload word
        clear_log();
        fq = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_fq(1'b0);
        reset = 1'b1;
        #1;
        check("mr_cpu",   {31'd0, cpu_reset_o}, 32'd1);
        check("mr_busy",  {31'd0, busy_o}, 32'd0);
        check("mr_ready", {31'd0, bus.s_ready}, 32'd1);
        check("mr_data",  init_data, 32'd0);
        check("mr_addr",  {17'd0, instr_init_addr}, 32'd0);
        idle(2);
        reset = 1'b0;
        idle(6);
        check("mr_nwr", q_mem.size(), 32'd0);
        fq = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
        send_fq(1'b1);
        idle(3);
        check("mr2_nwr",   q_mem.size(), 32'd1);
        check("mr2_addr",  {17'd0, q_addr[0]}, 32'h20);
        check("mr2_data",  q_data[0], 32'h01020304);
        check("mr2_words", {16'd0, words_written_o}, 32'd1);
        check("mr2_err",   {31'd0, err_o}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        clear_log();
        fq = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_fq(1'b0);
        send_byte(8'h05);
        idle(2);
        check("ck_ok_err", {31'd0, err_o}, 32'd0);
        send_fq(1'b0);
        send_byte(8'h06);
        idle(2);
        check("ck_bad_err",  {31'd0, err_o}, 32'd1);
        check("ck_nwr",      q_mem.size(), 32'd2);
        check("ck_bad_data", q_data[1], 32'h04030201);
        check("ck_busy",     {31'd0, busy_o}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
